// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU result stage
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_SUM  = 2'b00,
        OP_DIFF = 2'b01,
        OP_ABS  = 2'b10,
        OP_MIN  = 2'b11
    } alu_op_t;

    // Saturation rails for a signed DATA_W result
    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sat;
        alu_op_t           op;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO of result_t entries with occupancy count
module result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  result_t                i_data,
    input  logic                   i_pop,
    output result_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    result_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    // Guard the handshakes so an overflow push or an underflow pop can never corrupt state
    always_comb begin
        o_full  = (r_count == FULL_CNT);
        o_empty = (r_count == '0);
        w_push  = i_push && !o_full;
        w_pop   = i_pop && !o_empty;
        o_head  = r_mem[r_rd_ptr];
        o_count = r_count;
    end

    // Storage, pointers and count; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - select/saturate ALU results and buffer them behind valid/ready
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [WIDTH-1:0]       sum,
    input  logic [WIDTH-1:0]       diff,
    input  logic [WIDTH-1:0]       abs_v,
    input  logic                   s_of,
    input  logic                   d_of,
    input  logic                   lt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_sat,
    output logic [1:0]             out_op,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic                   sat_clr,
    output logic [CNT_W-1:0]       sat_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    result_t    w_res;
    result_t    w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_pop;
    logic [CNT_W-1:0] r_sat_count;

    // Pick one result per opcode; on overflow clamp toward the sign of operand a
    always_comb begin
        w_res.data = sum;
        w_res.sat  = 1'b0;
        w_res.op   = alu_op_t'(op);
        case (alu_op_t'(op))
            OP_SUM: begin
                if (s_of) begin
                    w_res.data = a[WIDTH-1] ? SAT_NEG : SAT_POS;
                    w_res.sat  = 1'b1;
                end else begin
                    w_res.data = sum;
                end
            end
            OP_DIFF: begin
                if (d_of) begin
                    w_res.data = a[WIDTH-1] ? SAT_NEG : SAT_POS;
                    w_res.sat  = 1'b1;
                end else begin
                    w_res.data = diff;
                end
            end
            OP_ABS: begin
                // |most-negative| is not representable, nor is |sum| of an overflowed add
                if (s_of || (sum == SAT_NEG)) begin
                    w_res.data = SAT_POS;
                    w_res.sat  = 1'b1;
                end else begin
                    w_res.data = abs_v;
                end
            end
            OP_MIN: begin
                w_res.data = lt ? a : b;
            end
            default: begin
                w_res.data = sum;
            end
        endcase
    end

    // Handshakes; in_ready comes only from the registered count, never from out_ready
    always_comb begin
        in_ready   = !w_full;
        out_valid  = !w_empty;
        w_accept   = in_valid && !w_full;
        w_pop      = out_valid && out_ready;
        out_data   = w_head.data;
        out_sat    = w_head.sat;
        out_op     = w_head.op;
        sat_count  = r_sat_count;
    end

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (w_res),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Count accepted saturated results, sticking at all-ones; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_accept && w_res.sat && (r_sat_count != CNT_MAX)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a, b, sum, diff, abs_v;
    logic        s_of, d_of, lt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic [1:0]  out_op;
    logic [2:0]  fifo_count;
    logic        sat_clr;
    logic [7:0]  sat_count;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic [1:0]  o;
    } exp_t;

    exp_t q[$];
    int   m_sat = 0;

    alu_result_stage #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .sum        (sum),
        .diff       (diff),
        .abs_v      (abs_v),
        .s_of       (s_of),
        .d_of       (d_of),
        .lt         (lt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_op     (out_op),
        .fifo_count (fifo_count),
        .sat_clr    (sat_clr),
        .sat_count  (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Behaves like the upstream ALU: derive all flags from the operands with integer maths
    task automatic set_in(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv);
        int sa, sb, s, d;
        sa = $signed(av);
        sb = $signed(bv);
        s = sa + sb;
        d = sa - sb;
        op = o; a = av; b = bv;
        sum = s[15:0];
        diff = d[15:0];
        s_of = (s > 32767) || (s < -32768);
        d_of = (d > 32767) || (d < -32768);
        abs_v = sum[15] ? (~sum + 16'd1) : sum;
        lt = (sa < sb);
    endtask

    function automatic exp_t ref_result();
        exp_t e;
        int sa;
        sa = $signed(a);
        e.o = op;
        e.s = 1'b0;
        case (op)
            2'd0: if (s_of) begin e.s = 1'b1; e.d = (sa < 0) ? 16'h8000 : 16'h7FFF; end else e.d = sum;
            2'd1: if (d_of) begin e.s = 1'b1; e.d = (sa < 0) ? 16'h8000 : 16'h7FFF; end else e.d = diff;
            2'd2: if (s_of || sum == 16'h8000) begin e.s = 1'b1; e.d = 16'h7FFF; end else e.d = abs_v;
            default: e.d = lt ? a : b;
        endcase
        return e;
    endfunction

    // Advance one clock and update the reference FIFO and counter
    task automatic tick();
        exp_t e;
        bit acc, pp;
        acc = in_valid && (q.size() < DEPTH);
        pp = out_ready && (q.size() > 0);
        e = ref_result();
        if (sat_clr) m_sat = 0;
        else if (acc && e.s && m_sat != 255) m_sat++;
        @(posedge clk);
        #1;
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(e);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        set_in(2'd0, 16'h0, 16'h0);
        #3;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (fifo_count !== 3'd0) $display("FAIL rst_count got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (out_data !== 16'h0 || out_sat !== 1'b0 || out_op !== 2'd0)
            $display("FAIL rst_out got %h/%b/%0d want 0/0/0", out_data, out_sat, out_op); else n_pass++;
        n_total++; if (sat_count !== 8'd0) $display("FAIL rst_sat_count got %0d want 0", sat_count); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_sum();
        out_ready = 1'b1;
        set_in(2'd0, 16'h6C3C, 16'h0030); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1 || out_data !== 16'h6C6C || out_sat !== 1'b0 || out_op !== 2'd0)
            $display("FAIL sum_plain got v%b %h s%b op%0d want v1 6c6c s0 op0", out_valid, out_data, out_sat, out_op); else n_pass++;
        set_in(2'd0, 16'h1388, 16'h7530); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_data !== 16'h7FFF || out_sat !== 1'b1) $display("FAIL sum_pos_sat got %h s%b want 7fff s1", out_data, out_sat); else n_pass++;
        n_total++; if (sat_count !== 8'd1) $display("FAIL sum_pos_cnt got %0d want 1", sat_count); else n_pass++;
        set_in(2'd0, 16'h86E8, 16'hEC78); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_data !== 16'h8000 || out_sat !== 1'b1) $display("FAIL sum_neg_sat got %h s%b want 8000 s1", out_data, out_sat); else n_pass++;
        n_total++; if (sat_count !== 8'd2) $display("FAIL sum_neg_cnt got %0d want 2", sat_count); else n_pass++;
        drain();
    endtask

    task automatic test_abs();
        out_ready = 1'b1;
        set_in(2'd2, 16'hFB50, 16'h0000); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_data !== 16'h04B0 || out_sat !== 1'b0 || out_op !== 2'd2)
            $display("FAIL abs_plain got %h s%b op%0d want 04b0 s0 op2", out_data, out_sat, out_op); else n_pass++;
        set_in(2'd2, 16'h8000, 16'h0000); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_data !== 16'h7FFF || out_sat !== 1'b1) $display("FAIL abs_min_neg got %h s%b want 7fff s1", out_data, out_sat); else n_pass++;
        drain();
    endtask

    task automatic test_min();
        out_ready = 1'b1;
        set_in(2'd3, 16'hFF38, 16'h01F4); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_data !== 16'hFF38 || out_sat !== 1'b0 || out_op !== 2'd3)
            $display("FAIL min_lt got %h s%b op%0d want ff38 s0 op3", out_data, out_sat, out_op); else n_pass++;
        set_in(2'd3, 16'h01F4, 16'hFF38); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (out_data !== 16'hFF38) $display("FAIL min_swap got %h want ff38", out_data); else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(2'd0, 16'(i * 256), 16'h0001); in_valid = 1'b1; tick();
        end
        n_total++; if (fifo_count !== 3'd4) $display("FAIL bp_count got %0d want 4", fifo_count); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
        set_in(2'd0, 16'h5555, 16'h0001); in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_total++; if (fifo_count !== 3'd4 || out_data !== 16'h0001)
            $display("FAIL bp_fifth got count %0d head %h want 4 0001", fifo_count, out_data); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_data !== 16'(i * 256 + 1))
                $display("FAIL bp_order[%0d] got v%b %h want v1 %h", i, out_valid, out_data, 16'(i * 256 + 1)); else n_pass++;
            tick();
            if (i == 0) begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", in_ready); else n_pass++;
            end
        end
        n_total++; if (fifo_count !== 3'd0) $display("FAIL bp_drained got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_sat_clr();
        out_ready = 1'b1;
        set_in(2'd1, 16'h7FFF, 16'hFFFF); in_valid = 1'b1; tick();
        n_total++; if (out_data !== 16'h7FFF || sat_count !== 8'(m_sat))
            $display("FAIL diff_sat got %h cnt %0d want 7fff %0d", out_data, sat_count, m_sat); else n_pass++;
        sat_clr = 1'b1; tick(); sat_clr = 1'b0; in_valid = 1'b0;
        n_total++; if (sat_count !== 8'd0) $display("FAIL clr_priority got %0d want 0", sat_count); else n_pass++;
        drain();
    endtask

    task automatic test_sat_stick();
        out_ready = 1'b1;
        set_in(2'd0, 16'h7FFF, 16'h7FFF); in_valid = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        in_valid = 1'b0;
        n_total++; if (sat_count !== 8'd255) $display("FAIL sat_stick got %0d want 255", sat_count); else n_pass++;
        drain();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0: return 16'h7FFF - 16'($urandom_range(0, 3));
            1: return 16'h8000 + 16'($urandom_range(0, 3));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            n_total++; if (fifo_count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0))
                $display("FAIL rnd_state[%0d] got cnt %0d rdy %b v %b want %0d", c, fifo_count, in_ready, out_valid, q.size()); else n_pass++;
            n_total++; if (sat_count !== 8'(m_sat)) $display("FAIL rnd_sat[%0d] got %0d want %0d", c, sat_count, m_sat); else n_pass++;
            if (q.size() > 0) begin
                n_total++; if (out_data !== q[0].d || out_sat !== q[0].s || out_op !== q[0].o)
                    $display("FAIL rnd_head[%0d] got %h/%b/%0d want %h/%b/%0d", c, out_data, out_sat, out_op, q[0].d, q[0].s, q[0].o); else n_pass++;
            end
            set_in(2'($urandom_range(0, 3)), pick(), pick());
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sat_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        sat_clr = 1'b0;
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        set_in(2'd0, 16'h7000, 16'h7000); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        n_total++; if (fifo_count !== 3'd3) $display("FAIL mid_count_pre got %0d want 3", fifo_count); else n_pass++;
        rst_n = 1'b0;
        #2;
        n_total++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || sat_count !== 8'd0)
            $display("FAIL mid_rst got v%b cnt %0d sat %0d want 0 0 0", out_valid, fifo_count, sat_count); else n_pass++;
        q.delete();
        m_sat = 0;
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tick();
        n_total++; if (out_valid !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL mid_after got v%b cnt %0d want 0 0", out_valid, fifo_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sum();
        test_abs();
        test_min();
        test_backpressure();
        test_sat_clr();
        test_sat_stick();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage directly downstream of the 16-bit carry-lookahead ALU (`top_level`). It captures the ALU's combinational SUM/DIFF/ABS/overflow/LT outputs together with the operands, and selects one result per transaction by opcode. Signed overflow is saturated instead of wrapped. Results are buffered in a small FIFO behind a valid/ready handshake, so the consumer can apply backpressure without stalling the combinational adder.

## Interface
- `WIDTH`, 16, datapath width; matches the ALU.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 8, width of the saturation event counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream has a transaction.
- `in_ready`  out  1  stage can accept (= FIFO not full).
- `op`  in  2  result select; see Operation.
- `a`, `b`  in  WIDTH  operands as driven to the ALU.
- `sum`, `diff`, `abs_v`  in  WIDTH  ALU SUM, DIFF, ABS(SUM).
- `s_of`, `d_of`, `lt`  in  1  ALU sum overflow, diff overflow, signed a<b.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  WIDTH  selected, saturated result.
- `out_sat`  out  1  head entry was saturated.
- `out_op`  out  2  opcode of head entry.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy.
- `sat_clr`  in  1  synchronous clear of `sat_count`.
- `sat_count`  out  CNT_W  accepted saturated results; sticks at all-ones.

## Operation
- Accept occurs when `in_valid && in_ready`. Result is computed combinationally from the inputs present in that cycle and then written to the FIFO tail.
- Opcodes:
  - 00 SUM: sum; if `s_of`, result is 0x7FFF when `a[15]`=0, else 0x8000.
  - 01 DIFF: diff; if `d_of`, result is 0x7FFF when `a[15]`=0, else 0x8000.
  - 10 ABS: abs_v. If `s_of` or `sum`==0x8000, result is 0x7FFF.
  - 11 MIN: `lt ? a : b`. Never saturates.
- `sat` flag is 1 whenever a substitution was made. It is stored with the entry.
- Pop occurs when `out_valid && out_ready`. `out_*` always reflects the head entry; they are don't-care (held) when `out_valid`=0.
- Push and pop in the same cycle: count unchanged, both pointers advance. A push is never possible when full, because `in_ready`=0.
- Pointers wrap modulo DEPTH. `fifo_count` distinguishes full from empty.
- `sat_count` increments on each accepted saturated entry and holds at 2^CNT_W−1. `sat_clr` has priority over increment: the result is 0.
- Implicit FIFO states: EMPTY (count 0), PARTIAL, FULL (count DEPTH). Transitions are driven only by push/pop.

## Timing
- Reset values: pointers 0, `fifo_count` 0, `out_valid` 0, `out_data` 0, `out_sat` 0, `out_op` 0, `sat_count` 0.
- `in_ready`=1 while in reset and after it, because count is 0.
- Latency: an accept on edge N gives `out_valid`=1 after edge N, i.e. visible in cycle N+1. No bypass exists.
- Throughput: one transaction per cycle when `out_ready`=1.
- `in_ready` depends only on registered count. It has no combinational path from `out_ready`.
- Asserting reset mid-operation discards all entries immediately (asynchronously). No partial results are emitted after release.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum: OP_SUM, OP_DIFF, OP_ABS, OP_MIN.
  - `SAT_POS`=16'h7FFF and `SAT_NEG`=16'h8000.
  - `result_t` struct {data, sat, op}.
- Sub-module `result_fifo`: parameterized synchronous FIFO of `result_t`, DEPTH entries, with count output.
- Top level holds the select/saturate logic and the counter.

## Test plan
- SUM, no overflow: a=0x6C3C, b=0x0030, sum=0x6C6C, out_ready=1 → next cycle `out_data`=0x6C6C, `out_sat`=0, `out_op`=0.
- SUM, positive overflow: a=0x1388, b=0x7530, sum=0x88B8, s_of=1 → 0x7FFF, `out_sat`=1, `sat_count`=1. Negative case: a=0x86E8, b=0xEC78, s_of=1 → 0x8000, `sat_count`=2.
- ABS: sum=0xFB50, abs_v=0x04B0 → 0x04B0, sat 0. Then sum=0x8000, abs_v=0x8000 → 0x7FFF, sat 1.
- MIN: a=0xFF38, b=0x01F4, lt=1 → 0xFF38. Swap operands with lt=0 → 0xFF38.
- Backpressure: out_ready=0, push 4 entries → `fifo_count`=4, `in_ready`=0, fifth in_valid ignored. Then out_ready=1 → entries drain in order, one per cycle, and `in_ready` returns to 1 the cycle after the first pop.
- Reset mid-stream: 3 entries queued, pulse rst_n low → `out_valid`=0, count 0, `sat_count` 0. Check also that `sat_clr` coinciding with a saturated accept yields 0.
